dp_ingress_arbiter: RTL
=======================

// Module: dp_ingress_arbiter
// PURPOSE
//   Merges N_CH MAC rx byte streams into the single ingress stream feeding mac_rx_fifo_final.
//   Each packet is forwarded whole: once a channel is granted, no other channel's bytes are interleaved.
//   Arbitration is round-robin across enabled channels.
//   Packets longer than MAX_PKT_BYTES are truncated and flagged, and the rest of that packet is discarded.
//   Per-channel packet and truncation counters are readable by the control plane (picorv).
// PARAMETERS
//   N_CH           4     number of rx channels (2..16)
//   DATA_W         8     beat width in bits
//   MAX_PKT_BYTES  1518  maximum beats forwarded per packet
//   CNT_W          32    width of the statistics counters
// PORTS
//   clk          in   1              clock, all logic rising-edge
//   rst          in   1              asynchronous active-high reset
//   rx_valid     in   N_CH           per-channel beat valid
//   rx_data      in   N_CH*DATA_W    channel i occupies bits [i*DATA_W +: DATA_W]
//   rx_last      in   N_CH           per-channel end of packet
//   rx_ready     out  N_CH           per-channel ready
//   out_valid    out  1              merged beat valid
//   out_data     out  DATA_W         merged beat data
//   out_last     out  1              merged end of packet
//   out_chan     out  $clog2(N_CH)   source channel of the current beat
//   out_trunc    out  1              qualifies out_last: packet was truncated
//   out_ready    in   1              downstream ready
//   cfg_ch_en    in   N_CH           channel enable mask (sampled only in IDLE)
//   cnt_sel      in   $clog2(N_CH)   counter readout select
//   cnt_clr      in   1              synchronous clear of all counters (1-cycle pulse)
//   pkt_cnt      out  CNT_W          packets completed on channel cnt_sel (combinational mux)
//   trunc_cnt    out  CNT_W          packets truncated on channel cnt_sel
// BEHAVIOUR
//   Reset (async, immediate):
//     - FSM=IDLE; all counters=0; last_grant=N_CH-1, so ch0 wins first.
//     - rx_ready=0, out_valid=0, out_last=0, out_trunc=0, out_chan=0.
//   FSM states: IDLE, PASS, DISCARD.
//   IDLE
//     - req = rx_valid & cfg_ch_en.
//     - If req is nonzero, grant g = first set bit searching upward from last_grant+1, wrapping at N_CH.
//     - Register g and go to PASS. All rx_ready=0 and out_valid=0 in this cycle (1-cycle grant bubble).
//   PASS (combinational pass-through, 0 latency)
//     - out_valid=rx_valid[g]; out_data=rx_data[g]; rx_ready[g]=out_ready; all other rx_ready=0.
//     - out_chan=g throughout.
//     - A beat fires when rx_valid[g]&&out_ready. beat_cnt (16b) increments on each fire.
//     - Fire with rx_last[g]:
//         out_last=1, out_trunc=0; pkt_cnt[g]++; last_grant<=g; beat_cnt<=0; go to IDLE.
//     - Fire with beat_cnt==MAX_PKT_BYTES-1 and !rx_last[g]:
//         out_last=1, out_trunc=1; pkt_cnt[g]++; trunc_cnt[g]++; go to DISCARD.
//     - If the MAX-th beat also carries rx_last, it is a normal end (out_trunc=0).
//   DISCARD
//     - rx_ready[g]=1; out_valid=0.
//     - Input beats are consumed and dropped until a beat with rx_last[g].
//     - Then last_grant<=g, beat_cnt<=0, go to IDLE.
//   Counters
//     - Saturate at 2^CNT_W-1 (no wrap).
//     - cnt_clr has priority over an increment in the same cycle; the result is 0.
//   Other rules
//     - A channel dropping rx_valid mid-packet stalls the grant. There is no timeout.
//     - cfg_ch_en changes during PASS/DISCARD have no effect until the next IDLE.
//     - A disabled channel's rx_ready stays 0, so its MAC is backpressured.
//     - Single-beat packet (rx_last on the first beat): 1 beat forwarded, back to IDLE.
//     - Throughput is one packet per (len+1) cycles per grant.
// TESTING
//   1. Reset, then ch1 sends 4 beats AA..AD and last.
//      -> out_chan=1; 4 beats out, out_last on AD; pkt_cnt[1]=1; first beat appears 1 cycle after rx_valid.
//   2. ch0, ch2 and ch3 all valid, each sending a 3-beat packet, 2 rounds.
//      -> grant order 0,2,3,0,2,3; packets never interleave; pkt_cnt for ch0, ch2 and ch3 each =2.
//   3. MAX_PKT_BYTES=8; ch0 sends 12 beats.
//      -> 8 beats out, 8th with out_last=1 and out_trunc=1; 4 beats dropped; trunc_cnt[0]=1.
//      -> a following ch1 packet is forwarded intact.
//   4. out_ready toggles 1/0 every cycle during a 6-beat ch2 packet.
//      -> data order preserved, no beat lost or duplicated; rx_ready[2] mirrors out_ready.
//   5. cfg_ch_en=4'b1011 with ch2 valid; also assert rst in PASS on the third beat.
//      -> ch2 is never granted; after rst all outputs=0, counters=0, and the next grant goes to ch0.
//   6. Force pkt_cnt[0]=2^CNT_W-2, send 2 packets on ch0, then cnt_clr coincident with a ch0 last beat.
//      -> counter saturates at all-ones; after cnt_clr it reads 0.

Source files
------------

// File: rtl/dp_ingress_arbiter.sv
// Round-robin packet arbiter merging N_CH rx byte streams into one ingress stream.
// Packets are forwarded whole; oversize packets are truncated, flagged and their tail dropped.
module dp_ingress_arbiter #(
  parameter int N_CH          = 4,
  parameter int DATA_W        = 8,
  parameter int MAX_PKT_BYTES = 1518,
  parameter int CNT_W         = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH-1:0]           rx_valid,
  input  logic [N_CH*DATA_W-1:0]    rx_data,
  input  logic [N_CH-1:0]           rx_last,
  output logic [N_CH-1:0]           rx_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  output logic [$clog2(N_CH)-1:0]   out_chan,
  output logic                      out_trunc,
  input  logic                      out_ready,
  input  logic [N_CH-1:0]           cfg_ch_en,
  input  logic [$clog2(N_CH)-1:0]   cnt_sel,
  input  logic                      cnt_clr,
  output logic [CNT_W-1:0]          pkt_cnt,
  output logic [CNT_W-1:0]          trunc_cnt
);

  localparam int CH_W = $clog2(N_CH);
  localparam logic [15:0] MAX_IDX = 16'(MAX_PKT_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_PASS, S_DISCARD} state_t;

  state_t            r_state, w_nextState;
  logic [CH_W-1:0]   r_grant, r_lastGrant, w_rrWinner, w_rrCand;
  logic              w_rrFound;
  int                w_rrIdx;
  logic [15:0]       r_beatCnt;
  logic [CNT_W-1:0]  r_pktCnt   [N_CH];
  logic [CNT_W-1:0]  r_truncCnt [N_CH];
  logic [N_CH-1:0]   w_req;
  logic              w_gValid, w_gLast, w_atMax, w_fire, w_pktInc, w_truncInc, w_discEnd;

  assign w_req      = rx_valid & cfg_ch_en;
  assign w_gValid   = rx_valid[r_grant];
  assign w_gLast    = rx_last[r_grant];
  assign w_atMax    = (r_beatCnt == MAX_IDX);
  assign w_fire     = (r_state == S_PASS) && w_gValid && out_ready;
  assign w_pktInc   = w_fire && (w_gLast || w_atMax);
  assign w_truncInc = w_fire && w_atMax && !w_gLast;
  assign w_discEnd  = (r_state == S_DISCARD) && w_gValid && w_gLast;

  // Search upward from the channel after the last completed grant, wrapping at N_CH.
  always_comb begin
    w_rrFound  = 1'b0;
    w_rrWinner = '0;
    w_rrIdx    = 0;
    w_rrCand   = '0;
    for (int k = 1; k <= N_CH; k++) begin
      w_rrIdx = int'(r_lastGrant) + k;
      if (w_rrIdx >= N_CH) w_rrIdx = w_rrIdx - N_CH;
      w_rrCand = CH_W'(w_rrIdx);
      if (!w_rrFound && w_req[w_rrCand]) begin
        w_rrFound  = 1'b1;
        w_rrWinner = w_rrCand;
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    rx_ready    = '0;
    out_valid   = 1'b0;
    out_data    = '0;
    out_last    = 1'b0;
    out_trunc   = 1'b0;
    out_chan    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_rrFound) w_nextState = S_PASS;
      end
      S_PASS: begin
        out_valid         = w_gValid;
        out_data          = rx_data[r_grant*DATA_W +: DATA_W];
        out_last          = w_gValid && (w_gLast || w_atMax);
        out_trunc         = w_gValid && w_atMax && !w_gLast;
        out_chan          = r_grant;
        rx_ready[r_grant] = out_ready;
        if (w_fire && w_gLast)      w_nextState = S_IDLE;
        else if (w_fire && w_atMax) w_nextState = S_DISCARD;
      end
      S_DISCARD: begin
        out_chan          = r_grant;
        rx_ready[r_grant] = 1'b1;
        if (w_discEnd) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Reset points last grant at the top channel so channel 0 wins the first arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_lastGrant <= CH_W'(N_CH - 1);
      r_beatCnt   <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == S_IDLE && w_rrFound) r_grant <= w_rrWinner;
      if (w_fire) begin
        if (w_gLast) begin
          r_beatCnt   <= '0;
          r_lastGrant <= r_grant;
        end else begin
          r_beatCnt <= r_beatCnt + 16'd1;
        end
      end
      if (w_discEnd) begin
        r_beatCnt   <= '0;
        r_lastGrant <= r_grant;
      end
    end
  end

  // Saturating statistics; a clear in the same cycle wins over an increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        r_pktCnt[i]   <= '0;
        r_truncCnt[i] <= '0;
      end
    end else if (cnt_clr) begin
      for (int i = 0; i < N_CH; i++) begin
        r_pktCnt[i]   <= '0;
        r_truncCnt[i] <= '0;
      end
    end else begin
      if (w_pktInc && r_pktCnt[r_grant] != CNT_MAX)
        r_pktCnt[r_grant] <= r_pktCnt[r_grant] + CNT_W'(1);
      if (w_truncInc && r_truncCnt[r_grant] != CNT_MAX)
        r_truncCnt[r_grant] <= r_truncCnt[r_grant] + CNT_W'(1);
    end
  end

  assign pkt_cnt   = r_pktCnt[cnt_sel];
  assign trunc_cnt = r_truncCnt[cnt_sel];

endmodule
